// File: rtl/niosii_system_sysid_checker.sv
// System ID checker: Avalon-MM read master that fetches the sysid ID word
// and timestamp word, compares them against build-time values and reports
// pass / mismatch / timeout with bounded retries.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489510081,
  parameter int          TIMEOUT_CYCLES     = 16,
  parameter int          MAX_RETRIES        = 3,
  parameter int          AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        id_mismatch,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PASS  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;
  localparam logic [2:0] S_RETRY = 3'd6;  // one idle cycle between attempts

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  // The read is abandoned on the edge that would bring the stall count to
  // TIMEOUT_CYCLES, so every attempt shows exactly TIMEOUT_CYCLES stalled
  // strobe cycles on the bus.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [2:0]    state_q, state_d;
  logic          read_q, read_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          auto_q;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic          mism_q, mism_d;
  logic          terr_q, terr_d;
  logic [31:0]   cap_id_q, cap_id_d;
  logic [31:0]   cap_ts_q, cap_ts_d;

  logic accept;
  logic stall;

  assign accept = read_q && !avm_waitrequest;
  assign stall  = read_q && avm_waitrequest;

  // Next-state, handshake, timeout/retry and result-flag logic
  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    done_d   = done_q;
    ok_d     = ok_q;
    mism_d   = mism_q;
    terr_d   = terr_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;

    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        // auto_q is only ever set during the first cycle after reset,
        // when the machine is necessarily in IDLE
        if (start || auto_q) begin
          state_d = S_RD_ID;
          read_d  = 1'b1;
          tmo_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          ok_d    = 1'b0;
          mism_d  = 1'b0;
          terr_d  = 1'b0;
        end
      end

      S_RD_ID, S_RD_TS: begin
        if (!read_q) begin
          // gap cycle after the ID read: raise the timestamp strobe next
          read_d = 1'b1;
        end else if (accept) begin
          tmo_d  = '0;
          read_d = 1'b0;
          if (state_q == S_RD_ID) begin
            cap_id_d = avm_readdata;
            state_d  = S_RD_TS;
          end else begin
            cap_ts_d = avm_readdata;
            state_d  = S_CHECK;
          end
        end else if (stall) begin
          if (tmo_q >= TMO_LAST) begin
            read_d = 1'b0;
            tmo_d  = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_RETRY;
            end else begin
              state_d = S_FAIL;
              done_d  = 1'b1;
              terr_d  = 1'b1;
              mism_d  = 1'b0;
              ok_d    = 1'b0;
            end
          end else if (tmo_q < TMO_LIMIT) begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end

      S_CHECK: begin
        done_d = 1'b1;
        if (cap_id_q == EXPECTED_ID && cap_ts_q == EXPECTED_TIMESTAMP) begin
          ok_d    = 1'b1;
          state_d = S_PASS;
        end else begin
          mism_d  = 1'b1;
          state_d = S_FAIL;
        end
      end

      S_RETRY: begin
        // restart from the ID word; retry count is kept
        state_d = S_RD_ID;
        read_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      tmo_q    <= '0;
      retry_q  <= '0;
      auto_q   <= (AUTO_START != 0);
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      mism_q   <= 1'b0;
      terr_q   <= 1'b0;
      cap_id_q <= '0;
      cap_ts_q <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      auto_q   <= 1'b0;
      done_q   <= done_d;
      ok_q     <= ok_d;
      mism_q   <= mism_d;
      terr_q   <= terr_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = (state_q == S_RD_TS);
  assign busy        = (state_q == S_RD_ID) || (state_q == S_RD_TS) ||
                       (state_q == S_CHECK) || (state_q == S_RETRY);
  assign done        = done_q;
  assign id_ok       = ok_q;
  assign id_mismatch = mism_q;
  assign timeout_err = terr_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker with a small Avalon slave model.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1489510081;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        id_mismatch;
  logic        timeout_err;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  logic [31:0] id_val;
  logic [31:0] ts_val;
  logic        wait_stuck;
  int          ts_stall_n;
  int          ts_stall_cnt;

  int total;
  int bad;

  niosii_system_sysid_checker dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .id_mismatch    (id_mismatch),
    .timeout_err    (timeout_err),
    .captured_id    (captured_id),
    .captured_ts    (captured_ts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model: zero-latency data, optional stall on the timestamp read
  assign avm_readdata    = avm_address ? ts_val : id_val;
  assign avm_waitrequest = wait_stuck ||
                           (avm_read && avm_address && (ts_stall_cnt < ts_stall_n));

  // Counts stalled timestamp cycles; restarts whenever the strobe is low
  always @(posedge clock) begin
    if (!avm_read)
      ts_stall_cnt <= 0;
    else if (avm_address && avm_waitrequest)
      ts_stall_cnt <= ts_stall_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++;
    if ({avm_read, avm_address, busy, done, id_ok, id_mismatch, timeout_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {avm_read, avm_address, busy, done, id_ok, id_mismatch, timeout_err});
    end
    total++;
    if (captured_id !== 32'd0 || captured_ts !== 32'd0) begin
      bad++;
      $display("FAIL reset_capture: got id=%h ts=%h want 0/0", captured_id, captured_ts);
    end
    $display("reset: outputs idle");
  endtask

  // AUTO_START from reset release: reads in cycles 1 and 3, done in cycle 5
  task automatic test_nominal();
    reset_n = 1'b1;
    tick();  // cycle 1
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_c1: got read=%b addr=%b busy=%b want 1 0 1", avm_read, avm_address, busy);
    end
    tick();  // cycle 2
    total++;
    if (avm_read !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_c2_gap: got read=%b busy=%b want 0 1", avm_read, busy);
    end
    tick();  // cycle 3
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
      bad++;
      $display("FAIL nom_c3: got read=%b addr=%b want 1 1", avm_read, avm_address);
    end
    tick();  // cycle 4
    total++;
    if (avm_read !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_c4: got read=%b done=%b busy=%b want 0 0 1", avm_read, done, busy);
    end
    tick();  // cycle 5
    total++;
    if ({done, id_ok, id_mismatch, timeout_err, busy} !== 5'b11000) begin
      bad++;
      $display("FAIL nom_c5_flags: got %b want 11000", {done, id_ok, id_mismatch, timeout_err, busy});
    end
    total++;
    if (captured_id !== 32'd0 || captured_ts !== TS_GOOD) begin
      bad++;
      $display("FAIL nom_capture: got id=%h ts=%h want 0/%h", captured_id, captured_ts, TS_GOOD);
    end
    $display("nominal: done=%b id_ok=%b ts=%h", done, id_ok, captured_ts);
  endtask

  task automatic test_mismatch();
    id_val = 32'd1;
    pulse_start();
    total++;
    if (done !== 1'b0 || id_ok !== 1'b0 || avm_read !== 1'b1) begin
      bad++;
      $display("FAIL mm_entry: got done=%b ok=%b read=%b want 0 0 1", done, id_ok, avm_read);
    end
    repeat (4) tick();
    total++;
    if ({done, id_ok, id_mismatch, timeout_err} !== 4'b1010 || captured_id !== 32'd1) begin
      bad++;
      $display("FAIL mm_result: got flags=%b id=%h want 1010 id=1",
               {done, id_ok, id_mismatch, timeout_err}, captured_id);
    end
    $display("mismatch: flags=%b id=%h", {done, id_ok, id_mismatch, timeout_err}, captured_id);
    id_val = 32'd0;
    pulse_start();
    total++;
    if (done !== 1'b0 || id_mismatch !== 1'b0) begin
      bad++;
      $display("FAIL mm_rerun_clear: got done=%b mism=%b want 0 0", done, id_mismatch);
    end
    repeat (4) tick();
    total++;
    if ({done, id_ok, id_mismatch, timeout_err} !== 4'b1100) begin
      bad++;
      $display("FAIL mm_rerun_pass: got %b want 1100", {done, id_ok, id_mismatch, timeout_err});
    end
    $display("mismatch rerun: flags=%b", {done, id_ok, id_mismatch, timeout_err});
  endtask

  task automatic test_stall();
    int held;
    ts_stall_n = 5;
    pulse_start();  // cycle 1
    tick();         // cycle 2
    tick();         // cycle 3: first stalled timestamp cycle
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (avm_read === 1'b1 && avm_address === 1'b1 && avm_waitrequest === 1'b1) held++;
      tick();
    end
    total++;
    if (held !== 5) begin
      bad++;
      $display("FAIL stall_hold: got %0d stable stalled cycles want 5", held);
    end
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b1 || avm_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: got read=%b addr=%b wait=%b want 1 1 0",
               avm_read, avm_address, avm_waitrequest);
    end
    tick();
    tick();
    total++;
    if ({done, id_ok, id_mismatch, timeout_err} !== 4'b1100 || captured_ts !== TS_GOOD) begin
      bad++;
      $display("FAIL stall_result: got flags=%b ts=%h want 1100 ts=%h",
               {done, id_ok, id_mismatch, timeout_err}, captured_ts, TS_GOOD);
    end
    ts_stall_n = 0;
    $display("stall: held=%0d flags=%b", held, {done, id_ok, id_mismatch, timeout_err});
  endtask

  task automatic test_timeout();
    int good;
    wait_stuck = 1'b1;
    pulse_start();
    good = 0;
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 16; k++) begin
        if (avm_read === 1'b1 && avm_address === 1'b0 && busy === 1'b1) good++;
        tick();
      end
      if (a < 3) begin
        if (avm_read === 1'b0 && busy === 1'b1 && done === 1'b0) good++;
        tick();
      end
    end
    total++;
    if (good !== 67) begin
      bad++;
      $display("FAIL tmo_pattern: got %0d matching cycles want 67", good);
    end
    total++;
    if ({done, id_ok, id_mismatch, timeout_err, busy, avm_read} !== 6'b100100) begin
      bad++;
      $display("FAIL tmo_result: got %b want 100100",
               {done, id_ok, id_mismatch, timeout_err, busy, avm_read});
    end
    $display("timeout: cycles_ok=%0d flags=%b", good, {done, id_ok, id_mismatch, timeout_err});

    // release the stall partway through the third attempt
    pulse_start();
    for (int a = 0; a < 2; a++) repeat (17) tick();
    repeat (5) tick();
    wait_stuck = 1'b0;
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b0) begin
      bad++;
      $display("FAIL tmo_release_read: got read=%b addr=%b want 1 0", avm_read, avm_address);
    end
    repeat (4) tick();
    total++;
    if ({done, id_ok, id_mismatch, timeout_err} !== 4'b1100) begin
      bad++;
      $display("FAIL tmo_release_pass: got %b want 1100", {done, id_ok, id_mismatch, timeout_err});
    end
    $display("timeout release: flags=%b", {done, id_ok, id_mismatch, timeout_err});
  endtask

  task automatic test_reset_mid();
    ts_stall_n = 10;
    pulse_start();
    tick();
    tick();
    tick();  // stalled in the timestamp read
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got read=%b addr=%b want 1 1", avm_read, avm_address);
    end
    reset_n = 1'b0;
    tick();
    total++;
    if ({avm_read, avm_address, busy, done, id_ok, id_mismatch, timeout_err} !== 7'b0 ||
        captured_ts !== 32'd0 || captured_id !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_clear: got ctrl=%b ts=%h id=%h want 0",
               {avm_read, avm_address, busy, done, id_ok, id_mismatch, timeout_err},
               captured_ts, captured_id);
    end
    ts_stall_n = 0;
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (avm_read !== 1'b1 || avm_address !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_restart: got read=%b addr=%b busy=%b want 1 0 1",
               avm_read, avm_address, busy);
    end
    repeat (4) tick();
    total++;
    if ({done, id_ok} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_pass: got done=%b ok=%b want 1 1", done, id_ok);
    end
    $display("reset mid-read: restart ok, flags=%b", {done, id_ok, id_mismatch, timeout_err});
  endtask

  task automatic test_start_busy();
    int rises;
    int id_reads;
    logic prev_done;
    pulse_start();  // cycle 1
    prev_done = done;
    tick();         // cycle 2
    tick();         // cycle 3, RD_TS strobe
    start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0;
    id_reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 && prev_done !== 1'b1) rises++;
      if (avm_read === 1'b1 && avm_address === 1'b0) id_reads++;
      prev_done = done;
      tick();
    end
    total++;
    if (rises !== 1 || id_reads !== 0) begin
      bad++;
      $display("FAIL busy_start_ignored: got done_rises=%0d id_reads=%0d want 1 0", rises, id_reads);
    end
    pulse_start();
    total++;
    if (id_ok !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pass_restart_clear: got ok=%b busy=%b want 0 1", id_ok, busy);
    end
    repeat (4) tick();
    total++;
    if ({done, id_ok, id_mismatch, timeout_err} !== 4'b1100) begin
      bad++;
      $display("FAIL pass_restart_done: got %b want 1100", {done, id_ok, id_mismatch, timeout_err});
    end
    $display("start during busy: done_rises=%0d flags=%b", rises, {done, id_ok, id_mismatch, timeout_err});
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    start        = 1'b0;
    wait_stuck   = 1'b0;
    ts_stall_n   = 0;
    id_val       = 32'd0;
    ts_val       = TS_GOOD;
    test_reset();
    test_nominal();
    test_mismatch();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
